// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush bubbles and EX operand forwarding
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   id_*                     decoded instruction fields from the ID stage
//   exmem_*, memwb_*         producer write-back info for forwarding into EX
//   flush                    taken branch/jump: squash the instruction entering EX
//   ex_*                     EX-stage operands and pass-through control
//   stall_id                 hold PC and IF/ID (load-use hazard)
//   bubble_count             saturating count of bubbles inserted
module id_ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [31:0] id_pc,
   input  logic [31:0] id_rs_data,
   input  logic [31:0] id_rt_data,
   input  logic [31:0] id_imm,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   input  logic [4:0]  id_shamt,
   input  logic [4:0]  id_opselect,
   input  logic        id_alusrc,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        id_mem_write,
   input  logic        exmem_reg_write,
   input  logic [4:0]  exmem_rd,
   input  logic [31:0] exmem_res,
   input  logic        memwb_reg_write,
   input  logic [4:0]  memwb_rd,
   input  logic [31:0] memwb_res,
   input  logic        flush,
   output logic [4:0]  ex_opselect,
   output logic [31:0] ex_x,
   output logic [31:0] ex_y,
   output logic [4:0]  ex_shamt,
   output logic [31:0] ex_pc,
   output logic        ex_valid,
   output logic [4:0]  ex_rd,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write,
   output logic [31:0] ex_store_data,
   output logic        stall_id,
   output logic [15:0] bubble_count
);
   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        alusrc;
      logic [4:0]  opselect;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [31:0] pc;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
   } ex_t;
   ex_t         ex_q, ex_d;
   logic [15:0] bubble_count_q, bubble_count_d;
   logic        bubble;
   logic [31:0] fwd_rt;
   always_comb begin
      // flush squashes the consumer anyway, so it never needs to stall
      stall_id = !flush && ex_q.valid && ex_q.mem_read && ex_q.rd != 5'd0 && id_valid &&
                 (ex_q.rd == id_rs || ex_q.rd == id_rt);
      bubble = flush || stall_id;
      ex_d.valid     = id_valid && !bubble;
      ex_d.reg_write = id_valid && id_reg_write && !bubble;
      ex_d.mem_read  = id_valid && id_mem_read && !bubble;
      ex_d.mem_write = id_valid && id_mem_write && !bubble;
      ex_d.alusrc    = id_alusrc;
      ex_d.opselect  = bubble ? 5'd0 : id_opselect;
      ex_d.rs        = id_rs;
      ex_d.rt        = id_rt;
      ex_d.rd        = id_rd;
      ex_d.shamt     = id_shamt;
      ex_d.pc        = id_pc;
      ex_d.rs_data   = id_rs_data;
      ex_d.rt_data   = id_rt_data;
      ex_d.imm       = id_imm;
      bubble_count_d = (bubble && bubble_count_q != 16'hFFFF) ? bubble_count_q + 16'd1 : bubble_count_q;
      // EX/MEM is the younger producer, so it wins over MEM/WB; $0 is never forwarded
      ex_x = (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == ex_q.rs) ? exmem_res :
             (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == ex_q.rs) ? memwb_res : ex_q.rs_data;
      fwd_rt = (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == ex_q.rt) ? exmem_res :
               (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == ex_q.rt) ? memwb_res : ex_q.rt_data;
      ex_y = ex_q.alusrc ? ex_q.imm : fwd_rt;
      ex_store_data = fwd_rt;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q           <= '0;
         bubble_count_q <= '0;
      end else begin
         ex_q           <= ex_d;
         bubble_count_q <= bubble_count_d;
      end
   end
   assign ex_opselect  = ex_q.opselect;
   assign ex_shamt     = ex_q.shamt;
   assign ex_pc        = ex_q.pc;
   assign ex_valid     = ex_q.valid;
   assign ex_rd        = ex_q.rd;
   assign ex_reg_write = ex_q.reg_write;
   assign ex_mem_read  = ex_q.mem_read;
   assign ex_mem_write = ex_q.mem_write;
   assign bubble_count = bubble_count_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scoreboard bench for id_ex_stage
module tb_id_ex_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd, id_shamt, id_opselect;
   logic        id_alusrc, id_reg_write, id_mem_read, id_mem_write;
   logic        exmem_reg_write, memwb_reg_write;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_res, memwb_res;
   logic        flush;
   logic [4:0]  ex_opselect, ex_shamt, ex_rd;
   logic [31:0] ex_x, ex_y, ex_pc, ex_store_data;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall_id;
   logic [15:0] bubble_count;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
      .id_opselect(id_opselect), .id_alusrc(id_alusrc), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_res(exmem_res),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_res(memwb_res),
      .flush(flush),
      .ex_opselect(ex_opselect), .ex_x(ex_x), .ex_y(ex_y), .ex_shamt(ex_shamt), .ex_pc(ex_pc),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data),
      .stall_id(stall_id), .bubble_count(bubble_count)
   );

   typedef struct {
      string       name;
      bit          full;
      logic        v, rw, mr, mw, stall;
      logic [4:0]  op, rd, sh;
      logic [31:0] x, y, sd, pc;
      logic [15:0] bc;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int checks = 0;
   int failures = 0;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", n, act, req);
      end
   endtask

   function automatic exp_t bub(input string n, input logic [15:0] bc, input logic stall);
      exp_t r;
      r.name = n; r.full = 1'b0; r.v = 1'b0; r.rw = 1'b0; r.mr = 1'b0; r.mw = 1'b0;
      r.stall = stall; r.op = 5'd0; r.rd = 5'd0; r.sh = 5'd0;
      r.x = '0; r.y = '0; r.sd = '0; r.pc = '0; r.bc = bc;
      return r;
   endfunction

   function automatic exp_t full(input string n, input logic v, input logic [4:0] rd, input logic [4:0] op,
                                 input logic [4:0] sh, input logic [31:0] pc, input logic [31:0] x,
                                 input logic [31:0] y, input logic [31:0] sd, input logic rw, input logic mr,
                                 input logic mw, input logic stall, input logic [15:0] bc);
      exp_t r;
      r.name = n; r.full = 1'b1; r.v = v; r.rw = rw; r.mr = mr; r.mw = mw;
      r.stall = stall; r.op = op; r.rd = rd; r.sh = sh;
      r.x = x; r.y = y; r.sd = sd; r.pc = pc; r.bc = bc;
      return r;
   endfunction

   // monitor: compares whatever the EX stage presents against the oldest expectation
   always @(negedge clk) begin
      if (q.size() > 0) begin
         e = q.pop_front();
         chk({e.name, ".ex_valid"}, 32'(ex_valid), 32'(e.v));
         chk({e.name, ".ex_reg_write"}, 32'(ex_reg_write), 32'(e.rw));
         chk({e.name, ".ex_mem_read"}, 32'(ex_mem_read), 32'(e.mr));
         chk({e.name, ".ex_mem_write"}, 32'(ex_mem_write), 32'(e.mw));
         chk({e.name, ".ex_opselect"}, 32'(ex_opselect), 32'(e.op));
         chk({e.name, ".stall_id"}, 32'(stall_id), 32'(e.stall));
         chk({e.name, ".bubble_count"}, 32'(bubble_count), 32'(e.bc));
         if (e.full) begin
            chk({e.name, ".ex_rd"}, 32'(ex_rd), 32'(e.rd));
            chk({e.name, ".ex_shamt"}, 32'(ex_shamt), 32'(e.sh));
            chk({e.name, ".ex_pc"}, ex_pc, e.pc);
            chk({e.name, ".ex_x"}, ex_x, e.x);
            chk({e.name, ".ex_y"}, ex_y, e.y);
            chk({e.name, ".ex_store_data"}, ex_store_data, e.sd);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [4:0] op,
                         input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                         input logic alusrc, input logic rw, input logic mr, input logic mw);
      id_valid = v; id_pc = pc; id_rs = rs; id_rt = rt; id_rd = rd; id_shamt = sh; id_opselect = op;
      id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alusrc = alusrc;
      id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
   endtask

   task automatic set_fw(input logic erw, input logic [4:0] erd, input logic [31:0] eres,
                         input logic mrw, input logic [4:0] mrd, input logic [31:0] mres);
      exmem_reg_write = erw; exmem_rd = erd; exmem_res = eres;
      memwb_reg_write = mrw; memwb_rd = mrd; memwb_res = mres;
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      set_fw(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      q.push_back(full("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rst = 1'b0;
      set_id(1, 32'h100, 1, 2, 3, 0, 0, 5, 7, 0, 0, 1, 0, 0);
      tick();
      set_id(1, 32'h104, 6, 7, 8, 3, 5'b00001, 32'h10, 32'h20, 32'hFFFF_FFF0, 1, 0, 0, 1);
      q.push_back(full("add", 1, 3, 0, 0, 32'h100, 5, 7, 7, 1, 0, 0, 0, 0));
      tick();
      set_id(1, 32'h108, 4, 4, 10, 0, 0, 32'hAA, 32'hBB, 0, 0, 1, 0, 0);
      q.push_back(full("alusrc", 1, 8, 5'b00001, 3, 32'h104, 32'h10, 32'hFFFF_FFF0, 32'h20, 0, 0, 1, 0, 0));
      tick();
      set_id(1, 32'h10C, 4, 4, 11, 0, 0, 32'hAA, 32'hBB, 0, 0, 1, 0, 0);
      set_fw(1, 4, 32'h11, 1, 4, 32'h22);
      q.push_back(full("fwd_exmem", 1, 10, 0, 0, 32'h108, 32'h11, 32'h11, 32'h11, 1, 0, 0, 0, 0));
      tick();
      set_id(1, 32'h110, 2, 4, 12, 0, 0, 32'h33, 32'hBB, 32'h1234, 1, 1, 0, 0);
      set_fw(0, 4, 32'h11, 1, 4, 32'h22);
      q.push_back(full("fwd_memwb", 1, 11, 0, 0, 32'h10C, 32'h22, 32'h22, 32'h22, 1, 0, 0, 0, 0));
      tick();
      set_id(1, 32'h114, 0, 0, 13, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      set_fw(1, 4, 32'h11, 0, 0, 0);
      q.push_back(full("alusrc_fwd", 1, 12, 0, 0, 32'h110, 32'h33, 32'h1234, 32'h11, 1, 0, 0, 0, 0));
      tick();
      set_id(1, 32'h118, 1, 5, 5, 0, 0, 32'h40, 0, 4, 1, 1, 1, 0);
      set_fw(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
      q.push_back(full("zero_reg", 1, 13, 0, 0, 32'h114, 0, 0, 0, 1, 0, 0, 0, 0));
      tick();
      set_id(1, 32'h11C, 5, 2, 6, 0, 0, 32'h999, 3, 0, 0, 1, 0, 0);
      set_fw(0, 0, 0, 0, 0, 0);
      q.push_back(full("lw_use", 1, 5, 0, 0, 32'h118, 32'h40, 4, 0, 1, 1, 0, 1, 0));
      tick();
      q.push_back(bub("stall_bubble", 1, 0));
      tick();
      set_id(1, 32'h120, 1, 5, 5, 0, 0, 32'h40, 0, 4, 1, 1, 1, 0);
      set_fw(0, 0, 0, 1, 5, 32'h77);
      q.push_back(full("after_stall", 1, 6, 0, 0, 32'h11C, 32'h77, 3, 3, 1, 0, 0, 0, 1));
      tick();
      set_id(1, 32'h124, 5, 2, 6, 0, 0, 1, 3, 0, 0, 1, 0, 0);
      set_fw(0, 0, 0, 0, 0, 0);
      flush = 1'b1;
      q.push_back(full("lw_flush", 1, 5, 0, 0, 32'h120, 32'h40, 4, 0, 1, 1, 0, 0, 1));
      tick();
      flush = 1'b0;
      set_id(1, 32'h128, 1, 5, 5, 0, 0, 32'h40, 0, 4, 1, 1, 1, 0);
      q.push_back(bub("flush_bubble", 2, 0));
      tick();
      set_id(0, 32'h12C, 5, 5, 7, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      q.push_back(full("lw_idle", 1, 5, 0, 0, 32'h128, 32'h40, 4, 0, 1, 1, 0, 0, 2));
      tick();
      set_id(1, 32'h130, 1, 2, 9, 0, 0, 1, 2, 0, 0, 1, 0, 0);
      q.push_back(bub("id_invalid", 2, 0));
      tick();
      rst = 1'b1;
      flush = 1'b1;
      q.push_back(full("pre_reset", 1, 9, 0, 0, 32'h130, 1, 2, 2, 1, 0, 0, 0, 2));
      tick();
      rst = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      q.push_back(full("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (65533) tick();
      tick();
      q.push_back(bub("sat_fffe", 16'hFFFE, 0));
      tick();
      q.push_back(bub("sat_ffff", 16'hFFFF, 0));
      tick();
      q.push_back(bub("sat_hold", 16'hFFFF, 0));
      flush = 1'b0;
      for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
